// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: Wishbone master that drains a byte FIFO into a 16550 THR.
// It polls LSR for THRE, then bursts up to BURST_MAX bytes, so the host never has to.
module uart_tx_sequencer #(
   parameter int         FIFO_AW   = 5,
   parameter int         BURST_MAX = 16,
   parameter int         POLL_GAP  = 8,
   parameter int         TO_WIDTH  = 4,
   parameter logic [3:0] LSR_ADR   = 4'h5,
   parameter logic [3:0] THR_ADR   = 4'h0
) (
   input  logic               WBs_CLK_i,
   input  logic               WBs_RST_i,
   input  logic               Enable_i,
   input  logic [7:0]         Tx_Data_i,
   input  logic               Tx_Push_i,
   output logic               Tx_Full_o,
   output logic [FIFO_AW:0]   Tx_Level_o,
   output logic               Overflow_o,
   output logic               Bus_Err_o,
   input  logic               Err_Clr_i,
   output logic               Busy_o,
   output logic [3:0]         WBm_ADR_o,
   output logic               WBm_CYC_o,
   output logic               WBm_STB_o,
   output logic               WBm_WE_o,
   output logic [7:0]         WBm_DAT_o,
   input  logic [15:0]        WBm_DAT_i,
   input  logic               WBm_ACK_i
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int GAP_W = $clog2(POLL_GAP + 1);
   localparam logic [FIFO_AW:0]    DEPTH_L  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]    BURST_L  = (FIFO_AW + 1)'(BURST_MAX);
   localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(POLL_GAP - 1);
   localparam logic [TO_WIDTH-1:0] TO_TRIP  = TO_WIDTH'((2 ** TO_WIDTH) - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POLL,
      S_EVAL,
      S_WRITE,
      S_GAP
   } state_t;

   state_t              state;
   logic [7:0]          mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr;
   logic [FIFO_AW-1:0]  rd_ptr;
   logic [FIFO_AW:0]    level;
   logic [FIFO_AW:0]    burst_cnt;
   logic [TO_WIDTH-1:0] to_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                thre;
   logic                full;
   logic                push_ok;
   logic                pop;
   logic                timeout;
   logic                unused_dat;

   assign full       = (level == DEPTH_L);
   assign push_ok    = Tx_Push_i && !full;
   assign pop        = (state == S_WRITE) && WBm_STB_o && WBm_ACK_i;
   assign timeout    = WBm_STB_o && !WBm_ACK_i && (to_cnt == TO_TRIP);
   assign Tx_Full_o  = full;
   assign Tx_Level_o = level;
   assign Busy_o     = (state != S_IDLE);
   assign unused_dat = ^{WBm_DAT_i[15:6], WBm_DAT_i[4:0]};

   // FIFO storage is not reset; only the pointers define what is valid
   always_ff @(posedge WBs_CLK_i) begin
      if (push_ok) begin
         mem[wr_ptr] <= Tx_Data_i;
      end
   end

   // FIFO pointers and occupancy; a push while full is dropped even if a pop frees a slot
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         end
         if (push_ok && !pop) begin
            level <= level + (FIFO_AW + 1)'(1);
         end else if (pop && !push_ok) begin
            level <= level - (FIFO_AW + 1)'(1);
         end
      end
   end

   // Sticky error flags; a clear wins over a same-cycle set
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         Overflow_o <= 1'b0;
         Bus_Err_o  <= 1'b0;
      end else if (Err_Clr_i) begin
         Overflow_o <= 1'b0;
         Bus_Err_o  <= 1'b0;
      end else begin
         if (Tx_Push_i && full) begin
            Overflow_o <= 1'b1;
         end
         if (timeout) begin
            Bus_Err_o <= 1'b1;
         end
      end
   end

   // Sequencer: every bus cycle is followed by at least one idle cycle, and each strobe is timeout-guarded
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         state     <= S_IDLE;
         WBm_CYC_o <= 1'b0;
         WBm_STB_o <= 1'b0;
         WBm_WE_o  <= 1'b0;
         WBm_ADR_o <= '0;
         WBm_DAT_o <= '0;
         thre      <= 1'b0;
         burst_cnt <= '0;
         to_cnt    <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Enable_i && (level != '0)) begin
                  state     <= S_POLL;
                  WBm_CYC_o <= 1'b1;
                  WBm_STB_o <= 1'b1;
                  WBm_WE_o  <= 1'b0;
                  WBm_ADR_o <= LSR_ADR;
                  to_cnt    <= '0;
               end
            end
            S_POLL: begin
               if (WBm_ACK_i) begin
                  thre      <= WBm_DAT_i[5];
                  WBm_CYC_o <= 1'b0;
                  WBm_STB_o <= 1'b0;
                  state     <= S_EVAL;
               end else if (timeout) begin
                  WBm_CYC_o <= 1'b0;
                  WBm_STB_o <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_WIDTH'(1);
               end
            end
            S_EVAL: begin
               if (!Enable_i || (level == '0)) begin
                  state <= S_IDLE;
               end else if (thre) begin
                  burst_cnt <= (level > BURST_L) ? BURST_L : level;
                  WBm_CYC_o <= 1'b1;
                  WBm_STB_o <= 1'b1;
                  WBm_WE_o  <= 1'b1;
                  WBm_ADR_o <= THR_ADR;
                  WBm_DAT_o <= mem[rd_ptr];
                  to_cnt    <= '0;
                  state     <= S_WRITE;
               end else begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end
            end
            S_WRITE: begin
               if (WBm_STB_o) begin
                  if (WBm_ACK_i) begin
                     WBm_CYC_o <= 1'b0;
                     WBm_STB_o <= 1'b0;
                     WBm_WE_o  <= 1'b0;
                     burst_cnt <= burst_cnt - (FIFO_AW + 1)'(1);
                  end else if (timeout) begin
                     WBm_CYC_o <= 1'b0;
                     WBm_STB_o <= 1'b0;
                     WBm_WE_o  <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     to_cnt <= to_cnt + TO_WIDTH'(1);
                  end
               end else if ((burst_cnt == '0) || (level == '0) || !Enable_i) begin
                  if (Enable_i && (level != '0)) begin
                     WBm_CYC_o <= 1'b1;
                     WBm_STB_o <= 1'b1;
                     WBm_WE_o  <= 1'b0;
                     WBm_ADR_o <= LSR_ADR;
                     to_cnt    <= '0;
                     state     <= S_POLL;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  WBm_CYC_o <= 1'b1;
                  WBm_STB_o <= 1'b1;
                  WBm_WE_o  <= 1'b1;
                  WBm_ADR_o <= THR_ADR;
                  WBm_DAT_o <= mem[rd_ptr];
                  to_cnt    <= '0;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (Enable_i) begin
                     WBm_CYC_o <= 1'b1;
                     WBm_STB_o <= 1'b1;
                     WBm_WE_o  <= 1'b0;
                     WBm_ADR_o <= LSR_ADR;
                     to_cnt    <= '0;
                     state     <= S_POLL;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Wishbone master that feeds the on-fabric UART_16550 transmitter, so the host does not have to poll LSR.
- Producer logic pushes bytes into an internal FIFO.
- The sequencer polls the UART LSR for THRE, then bursts up to BURST_MAX bytes into THR, and repeats until the FIFO is empty.
- Sits in front of the UART's Wishbone slave port, alongside the host-decoded path.

Parameters:
- FIFO_AW, 5: FIFO address width; depth = 2**FIFO_AW = 32 bytes.
- BURST_MAX, 16: max THR writes per THRE observation (16550 TX FIFO depth).
- POLL_GAP, 8: idle cycles between LSR polls when THRE=0.
- TO_WIDTH, 4: ACK timeout counter width; timeout at 2**TO_WIDTH-1 = 15 cycles.
- LSR_ADR, 4'h5: UART word address of LSR.
- THR_ADR, 4'h0: UART word address of THR.

Ports:
- WBs_CLK_i  in  1  single clock.
- WBs_RST_i  in  1  asynchronous, active-high reset.
- Enable_i  in  1  sequencer run enable.
- Tx_Data_i  in  8  byte to enqueue.
- Tx_Push_i  in  1  enqueue strobe, one byte per cycle.
- Tx_Full_o  out  1  FIFO full.
- Tx_Level_o  out  FIFO_AW+1  FIFO occupancy, 0..32.
- Overflow_o  out  1  sticky: push while full.
- Bus_Err_o  out  1  sticky: ACK timeout.
- Err_Clr_i  in  1  clears Overflow_o and Bus_Err_o.
- Busy_o  out  1  state != IDLE.
- WBm_ADR_o  out  4  UART word address.
- WBm_CYC_o  out  1  cycle.
- WBm_STB_o  out  1  strobe.
- WBm_WE_o  out  1  write enable.
- WBm_DAT_o  out  8  write data.
- WBm_DAT_i  in  16  read data; bit 5 = THRE.
- WBm_ACK_i  in  1  acknowledge.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE; FIFO pointers 0; counters 0.
  - Reset mid-transaction drops CYC/STB immediately; a partially sent burst is not resumed.
- FIFO:
  - Push when Tx_Full_o=1 is dropped and sets Overflow_o, even if a pop occurs the same cycle.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo depth; Tx_Level_o distinguishes full (32) from empty (0).
  - Pop happens on the ACK of a THR write.
- Err_Clr_i has priority over a same-cycle set of either sticky flag.
- States:
  - IDLE: if Enable_i && level>0, go to POLL next cycle.
  - POLL:
    - CYC=STB=1, WE=0, ADR=LSR_ADR, all registered; held until ACK.
    - On ACK: capture WBm_DAT_i[5]; drop CYC/STB next cycle; go to EVAL.
  - EVAL:
    - THRE=1 && level>0: burst_cnt = min(level, BURST_MAX); go to WRITE.
    - THRE=0: go to GAP.
    - level=0 or !Enable_i: go to IDLE.
  - WRITE:
    - CYC=STB=WE=1, ADR=THR_ADR, DAT_o = FIFO head; held until ACK.
    - On ACK: pop; burst_cnt-1; drop CYC/STB for one cycle (no back-to-back strobes).
    - Then: if burst_cnt hits 0, or FIFO empty, or !Enable_i, go to EVAL-free return: POLL if Enable_i && level>0, else IDLE.
    - Otherwise repeat WRITE.
  - GAP: count POLL_GAP cycles, then POLL (or IDLE if !Enable_i).
- Timeout:
  - Counter runs while CYC=1 without ACK, cleared on each new strobe.
  - On reaching 15: drop CYC/STB; set Bus_Err_o; no pop; go to IDLE.
  - Re-entry from IDLE happens normally next cycle if still enabled.
- Enable_i deassert never truncates a bus cycle in progress; FIFO contents are retained.
- Latency: from first push into an empty FIFO with Enable_i=1 to first STB = 2 cycles.
- Busy_o is combinational from the state register.

Test Plan:
- Reset, push 3 bytes 0x41,0x42,0x43, model ACKs after 1 cycle with LSR=0x0060 -> one LSR read, then 3 THR writes in order; level 0; IDLE; Busy_o=0.
- Push 20 bytes, LSR always 0x0060 -> LSR read, 16 writes, LSR read, 4 writes; no CYC gap violations.
- LSR returns 0x0000 twice then 0x0020 -> two GAP periods of 8 cycles, then writes; no byte lost.
- Push 33 bytes with Enable_i=0 -> Tx_Full_o=1 at 32; Overflow_o=1; level 32; Err_Clr_i clears the flag.
- Slave never ACKs -> CYC drops after 15 cycles; Bus_Err_o=1; level unchanged; retry follows.
- Assert WBs_RST_i during a WRITE strobe -> CYC/STB/WE low same cycle; level 0; state IDLE.
